// File: rtl/inv_sqrt_sched.sv
// inv_sqrt_sched: round-robin scheduler sharing one pipelined inv_sqrt core.
// Results return with requester ID via a latency-aligned tag pipe.
module inv_sqrt_sched #(
  parameter int N       = 4,
  parameter int LATENCY = 36,
  parameter int MAX_OUT = 8,
  localparam int IDW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*32-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic [31:0]     core_x_out,
  output logic            core_valid_out,
  input  logic [31:0]     core_y_in,
  input  logic            core_valid_in,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [31:0]     rsp_data,
  output logic            busy,
  output logic            err
);

  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int GW  = $clog2(LATENCY + 2);
  localparam int IW1 = IDW + 1;

  localparam logic [CW-1:0]  CMAX    = CW'(MAX_OUT);
  localparam logic [GW-1:0]  GMAX    = GW'(LATENCY + 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);
  localparam logic [IW1-1:0] N_W     = IW1'(N);

  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt_q [N];
  logic [N-1:0]   eligible;
  logic           grant_v;
  logic [IDW-1:0] grant_id;
  logic [31:0]    sel_data;

  logic [31:0]    core_x_q;
  logic           core_v_q;
  logic [IDW-1:0] issue_id_q;

  logic [LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];
  logic               tag_v;
  logic [IDW-1:0]     tag_id;

  logic [N-1:0]   inc;
  logic [N-1:0]   dec;
  logic [GW-1:0]  guard_q;
  logic           armed;
  logic           err_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = req_valid[i]
                  & (cnt_q[i] < CMAX)
                  & nrst;
    end
  end

  // scan rr_ptr, rr_ptr+1, ... wrapping at N
  always_comb begin
    logic [IW1-1:0] idx;
    grant_v  = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr} + IW1'(k);
      if (idx >= N_W) begin
        idx = idx - N_W;
      end
      if (!grant_v && eligible[idx[IDW-1:0]]) begin
        grant_v  = 1'b1;
        grant_id = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_v && grant_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
        sel_data     = req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rr_ptr <= '0;
    end else if (grant_v) begin
      if (grant_id == ID_LAST) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      core_v_q   <= 1'b0;
      core_x_q   <= '0;
      issue_id_q <= '0;
    end else begin
      core_v_q <= grant_v;
      if (grant_v) begin
        core_x_q   <= sel_data;
        issue_id_q <= grant_id;
      end
    end
  end

  assign core_x_out     = core_x_q;
  assign core_valid_out = core_v_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      tag_v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= core_v_q;
      tag_id_q[0] <= issue_id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign tag_v  = tag_v_q[LATENCY-1];
  assign tag_id = tag_id_q[LATENCY-1];

  // an untagged core result is never forwarded
  assign rsp_valid = core_valid_in & tag_v;
  assign rsp_id    = tag_id;
  assign rsp_data  = core_y_in;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      inc[i] = grant_v && (grant_id == IDW'(i));
      dec[i] = rsp_valid
            && (rsp_id == IDW'(i))
            && (cnt_q[i] != '0);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!nrst) begin
        cnt_q[g] <= '0;
      end else begin
        unique case ({inc[g], dec[g]})
          2'b10:   cnt_q[g] <= cnt_q[g] + 1'b1;
          2'b01:   cnt_q[g] <= cnt_q[g] - 1'b1;
          default: cnt_q[g] <= cnt_q[g];
        endcase
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      busy = busy | (cnt_q[i] != '0);
    end
  end

  // core may still drain pre-reset work for LATENCY+1 cycles
  always_ff @(posedge clk) begin
    if (!nrst) begin
      guard_q <= '0;
    end else if (guard_q != GMAX) begin
      guard_q <= guard_q + 1'b1;
    end
  end

  assign armed = (guard_q == GMAX);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (armed && (core_valid_in != tag_v)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_inv_sqrt_sched.sv
// tb_inv_sqrt_sched: directed bench for inv_sqrt_sched.
// A behavioural delay-line core stands in for the inv_sqrt datapath.
module tb_inv_sqrt_sched;

  localparam int N   = 4;
  localparam int LAT = 36;
  localparam int MO  = 8;

  logic          clk;
  logic          nrst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [31:0]   core_x_out;
  logic          core_valid_out;
  logic [31:0]   core_y_in;
  logic          core_valid_in;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          busy;
  logic          err;
  logic          inject;

  int n_tests = 0;
  int n_fail  = 0;

  inv_sqrt_sched #(
    .N(N), .LATENCY(LAT), .MAX_OUT(MO)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .core_x_out(core_x_out),
    .core_valid_out(core_valid_out),
    .core_y_in(core_y_in),
    .core_valid_in(core_valid_in),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] core_f(
    input logic [31:0] x
  );
    if (x == 32'h4080_0000) return 32'h3F00_0000;
    return ~x;
  endfunction

  // stand-in core: not reset, so pre-reset work drains
  logic [LAT-1:0] cp_v = '0;
  logic [31:0]    cp_d [LAT];

  always @(posedge clk) begin
    cp_v  <= {cp_v[LAT-2:0], core_valid_out};
    cp_d[0] <= core_f(core_x_out);
    for (int i = 1; i < LAT; i++) cp_d[i] <= cp_d[i-1];
  end

  assign core_valid_in = cp_v[LAT-1] | inject;
  assign core_y_in     = cp_d[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    req_valid = '0;
    step();
    nrst = 1'b1;
  endtask

  task automatic wait_rsp(
    input string      tag,
    input logic [1:0] id
  );
    int k;
    int d;
    k = -1;
    for (int j = 1; j <= LAT + 5; j++) begin
      step();
      if (rsp_valid) begin
        k = j;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(k), 32'(LAT));
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    d = int'(rsp_data) - int'(32'h3F00_0000);
    chk({tag, "_ulp"}, 32'(d <= 2 && d >= -2), 32'd1);
  endtask

  // mode 0: all four requesters; mode 1: only `id`
  task automatic run(
    input string tag,
    input int    mode,
    input int    id,
    input int    hold,
    input int    total
  );
    int          q_c [$];
    logic [1:0]  q_id [$];
    logic [31:0] q_d [$];
    int          n;
    int          outst;
    int          gid;
    logic        want;
    logic [3:0]  mask;
    logic [3:0]  exp_r;
    n     = 0;
    outst = 0;
    mask  = (mode == 0) ? 4'hf : 4'(1 << id);
    for (int c = 0; c < total; c++) begin
      req_valid = (c < hold) ? mask : 4'h0;
      for (int l = 0; l < N; l++) begin
        req_data[32*l +: 32] = {4'(l), 4'ha, 24'(c)};
      end
      #1;
      if (mode == 0) begin
        want = (c < hold) && (c < 4*MO || c >= LAT + 2);
        gid  = n % 4;
      end else begin
        want = (c < hold) && ((c % (LAT + 2)) < MO);
        gid  = id;
      end
      exp_r = want ? 4'(1 << gid) : 4'h0;
      chk({tag, "_ready"}, 32'(req_ready), 32'(exp_r));
      if (want) begin
        q_c.push_back(c);
        q_id.push_back(2'(gid));
        q_d.push_back({4'(gid), 4'ha, 24'(c)});
        n++;
        outst++;
      end
      step();
      chk({tag, "_busy"}, 32'(busy), 32'(outst != 0));
      if (q_c.size() > 0 && q_c[0] + LAT == c) begin
        chk({tag, "_rv"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rid"}, 32'(rsp_id), 32'(q_id[0]));
        chk({tag, "_rd"}, rsp_data, core_f(q_d[0]));
        void'(q_c.pop_front());
        void'(q_id.pop_front());
        void'(q_d.pop_front());
        outst--;
      end else begin
        chk({tag, "_rv0"}, 32'(rsp_valid), 32'd0);
      end
    end
    chk({tag, "_left"}, 32'(q_c.size()), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    nrst      = 1'b0;
    inject    = 1'b0;
    req_valid = '1;
    req_data  = '0;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_cvo", 32'(core_valid_out), 32'd0);
    chk("rst_cx", core_x_out, 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_rid", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    req_valid = '0;
    nrst      = 1'b1;
    step();

    // T1 single op
    req_valid = 4'b0001;
    req_data[31:0] = 32'h4080_0000;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("t1_cvo", 32'(core_valid_out), 32'd1);
    chk("t1_cx", core_x_out, 32'h4080_0000);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_rsp("t1", 2'd0);
    step();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_rv0", 32'(rsp_valid), 32'd0);
    chk("t1_cvo0", 32'(core_valid_out), 32'd0);
    chk("t1_hold", core_x_out, 32'h4080_0000);

    // T2 round robin
    do_reset();
    run("t2", 0, 0, 40, 80);

    // T3 credit stall on requester 2
    run("t3", 1, 2, 80, 120);

    // T4 streaming requester 1
    run("t4", 1, 1, 50, 90);

    // T5 mid-flight reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      req_data[31:0] = 32'h1234_5600 + 32'(i);
      step();
    end
    req_valid = '0;
    repeat (5) step();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    chk("t5_cvo", 32'(core_valid_out), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    for (int i = 0; i < 45; i++) begin
      step();
      chk("t5_rv", 32'(rsp_valid), 32'd0);
      chk("t5_bz", 32'(busy), 32'd0);
      chk("t5_er", 32'(err), 32'd0);
    end
    req_valid = 4'b1000;
    req_data[127:96] = 32'h4080_0000;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    wait_rsp("t5", 2'd3);
    chk("t5_data", rsp_data, 32'h3F00_0000);

    // T6 error injection
    do_reset();
    repeat (100) step();
    inject = 1'b1;
    #1;
    chk("t6_rv", 32'(rsp_valid), 32'd0);
    chk("t6_err0", 32'(err), 32'd0);
    step();
    inject = 1'b0;
    chk("t6_err1", 32'(err), 32'd1);
    repeat (5) step();
    chk("t6_sticky", 32'(err), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
